// File: rtl/shiftmult_n.sv
// Sequential shift-and-add multiplier, WIDTH x WIDTH -> 2*WIDTH, unsigned or two's-complement.
// Latency: start sampled at edge k, out/done valid after edge k+WIDTH; one multiplier bit per clock.
// Backpressure: start is ignored while busy=1 (not queued); start during the done cycle is accepted.
module shiftmult_n #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 sig,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     ina,
    input  logic [WIDTH-1:0]     inb,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   out
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state, state_nxt;
    logic               capture, finish;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] mcand, acc, acc_sum;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic               neg;

    // State register; reset wins over everything, including a same-cycle start.
    always_ff @(posedge clk) begin
        if (sig) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state plus the capture/finish strobes that steer the datapath.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    capture   = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (cnt == LAST) begin
                    finish    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand magnitudes (the most negative value negates to itself, which reads
    // correctly as an unsigned 2^(WIDTH-1)) and this step's partial sum.
    always_comb begin
        mag_a   = (signed_mode && ina[WIDTH-1]) ? -ina : ina;
        mag_b   = (signed_mode && inb[WIDTH-1]) ? -inb : inb;
        acc_sum = acc + (mplier[0] ? mcand : '0);
    end

    // Datapath: capture on start, one add/shift per RUN cycle, sign-fix on the last step.
    always_ff @(posedge clk) begin
        if (sig) begin
            busy   <= 1'b0;
            done   <= 1'b0;
            out    <= '0;
            cnt    <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            neg    <= 1'b0;
        end else begin
            done <= finish;
            if (capture) begin
                mcand  <= {{WIDTH{1'b0}}, mag_a};
                mplier <= mag_b;
                acc    <= '0;
                cnt    <= '0;
                neg    <= signed_mode & (ina[WIDTH-1] ^ inb[WIDTH-1]);
                busy   <= 1'b1;
            end else if (state == RUN) begin
                acc    <= acc_sum;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + 1'b1;
                if (finish) begin
                    out  <= neg ? -acc_sum : acc_sum;
                    busy <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_shiftmult_n.sv
// Self-checking bench for shiftmult_n at WIDTH=8 and WIDTH=16.
// Directed test-plan cases plus random operations against an arithmetic product model.
// Checks exact done/busy timing, out hold between operations, start-while-busy and mid-op reset.
module tb_shiftmult_n;

    logic        clk = 1'b0;
    logic        sig;
    logic        s8_start, s8_mode;
    logic [7:0]  s8_a, s8_b;
    logic        busy8, done8;
    logic [15:0] out8;
    logic        s16_start, s16_mode;
    logic [15:0] s16_a, s16_b;
    logic        busy16, done16;
    logic [31:0] out16;

    int          tests = 0;
    int          fails = 0;
    logic [63:0] hold8 = '0;
    logic [63:0] hold16 = '0;

    shiftmult_n #(.WIDTH(8)) dut8 (
        .clk(clk), .sig(sig), .start(s8_start), .signed_mode(s8_mode),
        .ina(s8_a), .inb(s8_b), .busy(busy8), .done(done8), .out(out8)
    );

    shiftmult_n #(.WIDTH(16)) dut16 (
        .clk(clk), .sig(sig), .start(s16_start), .signed_mode(s16_mode),
        .ina(s16_a), .inb(s16_b), .busy(busy16), .done(done16), .out(out16)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference product: interpret operands as plain integers and multiply.
    function automatic logic [63:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                          input logic m);
        longint ua, ub, p, half, full;
        full = longint'(1) << w;
        half = longint'(1) << (w - 1);
        ua = longint'(a) & (full - 1);
        ub = longint'(b) & (full - 1);
        if (m) begin
            if (ua >= half) ua = ua - full;
            if (ub >= half) ub = ub - full;
        end
        p = ua * ub;
        return 64'(p) & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    task automatic drive(input int w, input logic st, input logic [31:0] a, input logic [31:0] b,
                         input logic m);
        if (w == 8) begin
            s8_start = st; s8_a = a[7:0]; s8_b = b[7:0]; s8_mode = m;
        end else begin
            s16_start = st; s16_a = a[15:0]; s16_b = b[15:0]; s16_mode = m;
        end
    endtask

    function automatic logic obs_busy(input int w);
        return (w == 8) ? busy8 : busy16;
    endfunction

    function automatic logic obs_done(input int w);
        return (w == 8) ? done8 : done16;
    endfunction

    function automatic logic [63:0] obs_out(input int w);
        return (w == 8) ? 64'(out8) : 64'(out16);
    endfunction

    // One operation with exact cycle checks; returns in the done cycle so a following
    // call exercises the back-to-back path.
    task automatic op(input int w, input logic [31:0] a, input logic [31:0] b, input logic m,
                      input logic [63:0] exp, input string tag);
        logic [63:0] hold;
        hold = (w == 8) ? hold8 : hold16;
        @(negedge clk);
        drive(w, 1'b1, a, b, m);
        @(posedge clk);
        #1;
        drive(w, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, ~m);
        check({tag, " busy@start"}, 64'(obs_busy(w)), 64'd1);
        for (int i = 1; i <= w; i++) begin
            @(posedge clk);
            #1;
            if (i < w) begin
                check({tag, " busy"}, 64'(obs_busy(w)), 64'd1);
                check({tag, " done_early"}, 64'(obs_done(w)), 64'd0);
                check({tag, " out_hold"}, obs_out(w), hold);
            end else begin
                check({tag, " done"}, 64'(obs_done(w)), 64'd1);
                check({tag, " busy_end"}, 64'(obs_busy(w)), 64'd0);
                check({tag, " out"}, obs_out(w), exp);
            end
        end
        if (w == 8) hold8 = exp;
        else        hold16 = exp;
    endtask

    initial begin
        int          dcount;
        logic        sawdone;
        logic [31:0] ra, rb;
        logic        rm;
        int          rw;

        sig = 1'b1;
        drive(8, 1'b1, 32'd5, 32'd5, 1'b0);
        drive(16, 1'b1, 32'd5, 32'd5, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("rst busy8", 64'(busy8), 64'd0);
        check("rst done8", 64'(done8), 64'd0);
        check("rst out8", 64'(out8), 64'd0);
        check("rst busy16", 64'(busy16), 64'd0);
        check("rst out16", 64'(out16), 64'd0);
        @(negedge clk);
        sig = 1'b0;
        drive(8, 1'b0, 32'd0, 32'd0, 1'b0);
        drive(16, 1'b0, 32'd0, 32'd0, 1'b0);

        op(8, 32'd13, 32'd11, 1'b0, 64'h008F, "u13x11");
        op(8, 32'hFF, 32'hFF, 1'b0, 64'hFE01, "uFFxFF");
        op(8, 32'hFD, 32'd5, 1'b0, 64'h04F1, "uFDx5");
        op(8, 32'hFD, 32'd5, 1'b1, 64'hFFF1, "s-3x5");
        op(8, 32'h80, 32'h80, 1'b1, 64'h4000, "s-128x-128");
        op(8, 32'h80, 32'h7F, 1'b1, 64'hC080, "s-128x127");
        op(8, 32'h00, 32'hFF, 1'b1, 64'h0000, "s0x-1");
        op(16, 32'hFFFF, 32'hFFFF, 1'b0, 64'hFFFE0001, "w16 uFFFF");
        op(16, 32'h8000, 32'h0002, 1'b1, 64'hFFFF0000, "w16 s8000x2");

        // Start held high with operands changing every cycle: only the first capture counts.
        @(negedge clk);
        drive(8, 1'b1, 32'd21, 32'd6, 1'b0);
        @(posedge clk);
        #1;
        dcount = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            drive(8, (i < 8), $urandom, $urandom, 1'($urandom));
            @(posedge clk);
            #1;
            if (done8) dcount++;
        end
        check("hold_start out", 64'(out8), 64'd126);
        hold8 = 64'd126;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (done8) dcount++;
        end
        check("hold_start done_count", 64'(dcount), 64'd1);
        check("hold_start idle", 64'(busy8), 64'd0);

        // Reset four edges into an operation aborts it silently.
        @(negedge clk);
        drive(8, 1'b1, 32'd200, 32'd3, 1'b0);
        @(posedge clk);
        #1;
        drive(8, 1'b0, 32'd0, 32'd0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        sig = 1'b1;
        @(posedge clk);
        #1;
        check("midrst busy", 64'(busy8), 64'd0);
        check("midrst done", 64'(done8), 64'd0);
        check("midrst out", 64'(out8), 64'd0);
        check("midrst out16", 64'(out16), 64'd0);
        @(negedge clk);
        sig = 1'b0;
        sawdone = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (done8) sawdone = 1'b1;
        end
        check("midrst no_done", 64'(sawdone), 64'd0);
        hold8 = '0;
        hold16 = '0;
        op(8, 32'd7, 32'd9, 1'b0, 64'h003F, "after_rst 7x9");

        // Random operations, back-to-back, mixed widths and modes.
        for (int n = 0; n < 24; n++) begin
            rw = (n % 3 == 2) ? 16 : 8;
            ra = $urandom;
            rb = $urandom;
            rm = 1'($urandom);
            op(rw, ra, rb, rm, model(rw, ra, rb, rm), $sformatf("rand%0d w%0d", n, rw));
        end

        @(posedge clk);
        #1;
        check("final done8 drop", 64'(done8), 64'd0);
        check("final out8 hold", 64'(out8), hold8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
